// File: rtl/hrm_pkg.sv
// Shared definitions for the HRM CPU datapath: data width, opcodes and
// an elaboration-time log2 helper for pointer sizing.
package hrm_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    OP_INBOX    = 4'b0000,
    OP_OUTBOX   = 4'b0001,
    OP_COPYFROM = 4'b0010,
    OP_COPYTO   = 4'b0011,
    OP_ADD      = 4'b0100,
    OP_SUB      = 4'b0101,
    OP_BUMPUP   = 4'b0110,
    OP_BUMPDN   = 4'b0111,
    OP_JUMP     = 4'b1000,
    OP_JUMPZ    = 4'b1001,
    OP_JUMPN    = 4'b1010
  } opcode_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hrm_fifo_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and an asynchronous
// read port; shared by the inbox and outbox queues.
module hrm_fifo_ram
  import hrm_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = DATA_W
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic [clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]        o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset so the array can map to LUT RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hrm_inbox.sv
// First-word-fall-through input queue feeding the INBOX instruction; the head
// entry is visible on o_data whenever o_empty is low.
module hrm_inbox
  import hrm_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_wr,
  input  logic                  i_rd,
  input  logic                  i_clr,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [clog2(DEPTH):0] o_count,
  output logic                  o_ovf
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hrm_inbox: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_count;
  logic             r_ovf;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_wr_rej;
  logic             w_ram_we;
  logic [WIDTH-1:0] w_ram_rdata;

  // The extra MSB on each pointer distinguishes full from empty.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_rd_acc = i_rd & ~w_empty;
  assign w_wr_acc = i_wr & (~w_full | w_rd_acc);
  assign w_wr_rej = i_wr & w_full & ~i_rd;
  assign w_ram_we = w_wr_acc & ~i_clr;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + PW'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - PW'(1);
      end
      if (w_wr_rej) r_ovf <= 1'b1;
    end
  end

  hrm_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (i_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // Stale storage must not leak out while the queue is empty.
  assign o_data  = w_empty ? '0 : w_ram_rdata;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_hrm_inbox.sv
// Scoreboard bench for hrm_inbox: a byte-queue reference model predicts status
// and read data, a separate negedge monitor compares against the DUT.
module tb_hrm_inbox;

  localparam int DEPTH = 32;

  logic       clk;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_wr;
  logic       i_rd;
  logic       i_clr;
  logic [7:0] o_data;
  logic       o_empty;
  logic       o_full;
  logic [5:0] o_count;
  logic       o_ovf;

  hrm_inbox #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_wr    (i_wr),
    .i_rd    (i_rd),
    .i_clr   (i_clr),
    .o_data  (o_data),
    .o_empty (o_empty),
    .o_full  (o_full),
    .o_count (o_count),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic [5:0] count;
    logic       ovf;
  } st_t;

  st_t        sq[$];
  logic [7:0] rq[$];
  logic [7:0] mq[$];
  logic       m_ovf;
  int         checks;
  int         errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances by the queue rules.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    st_t s;
    bit  rd_ok;
    bit  wr_ok;
    @(posedge clk);
    #1;
    i_wr   = wr;
    i_data = d;
    i_rd   = rd;
    i_clr  = clr;
    s.empty = (mq.size() == 0);
    s.full  = (mq.size() == DEPTH);
    s.count = 6'(mq.size());
    s.ovf   = m_ovf;
    s.data  = s.empty ? 8'h00 : mq[0];
    sq.push_back(s);
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      rd_ok = rd && (mq.size() > 0);
      wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) begin
        rq.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (wr_ok) mq.push_back(d);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, 32'(o_empty), 32'd1);
    check({tag, "_full"},  32'(o_full),  32'd0);
    check({tag, "_count"}, 32'(o_count), 32'd0);
    check({tag, "_data"},  32'(o_data),  32'd0);
    check({tag, "_ovf"},   32'(o_ovf),   32'd0);
  endtask

  // Asserts reset between edges and checks the flags respond before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #1;
    i_wr = 1'b0; i_rd = 1'b0; i_clr = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Monitor: compares status every cycle and read data on every accepted read.
  initial begin
    st_t s;
    forever begin
      @(negedge clk);
      if (i_rst_n) begin
        if (sq.size() > 0) begin
          s = sq.pop_front();
          check("status_empty", 32'(o_empty), 32'(s.empty));
          check("status_full",  32'(o_full),  32'(s.full));
          check("status_count", 32'(o_count), 32'(s.count));
          check("status_ovf",   32'(o_ovf),   32'(s.ovf));
          check("head_data",    32'(o_data),  32'(s.data));
        end
        if (i_rd && !o_empty && !i_clr) begin
          if (rq.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
          else                check("rd_data", 32'(o_data), 32'(rq.pop_front()));
        end
      end
    end
  end

  int wp[4] = '{70, 30, 50, 95};
  int rp[4] = '{30, 70, 50, 95};

  initial begin
    checks  = 0;
    errors  = 0;
    m_ovf   = 1'b0;
    i_rst_n = 1'b0;
    i_wr    = 1'b0;
    i_rd    = 1'b0;
    i_clr   = 1'b0;
    i_data  = 8'h00;
    #2;
    check_reset_values("por");
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;

    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0, 1'b0);
    cycle(1'b1, 8'h7F, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill from a non-zero pointer so the drain crosses the wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (DEPTH) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (DEPTH) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    cycle(1'b1, 8'h42, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    async_reset();
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 500; k++) begin
        cycle(1'($urandom_range(99) < wp[ph]), 8'($urandom),
              1'($urandom_range(99) < rp[ph]), 1'($urandom_range(199) == 0));
      end
    end

    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("rd_queue_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
